// File: rtl/encipher_block.sv
// ---------------------------------------------------------------------------
// encipher_block
//   AES forward cipher datapath. It encrypts one 128-bit block and runs one
//   round per clock. Key expansion happens outside this block: the block
//   drives `round` to address an external round-key store, and it uses
//   `round_key` combinationally in the same cycle.
//
// Ports
//   clk        in   1    single clock, rising edge
//   reset_n    in   1    synchronous, active-low reset
//   next       in   1    start request, sampled only while ready=1
//   keylen     in   4    4'h2 = AES-256 (optional build), anything else = AES-128
//   round      out  4    index of the round key needed this cycle
//   round_key  in   128  key for `round`, valid in the same cycle
//   block      in   128  plaintext, sampled at start
//   new_block  out  128  ciphertext, holds the last completed result
//   ready      out  1    1 = idle/done, 0 = busy
//
// Configuration
//   ENCIPHER_AES256_EN : when defined, keylen==4'h2 selects 14 rounds.
//                        When undefined, keylen is ignored and the core
//                        always runs 10 rounds.
//
// Handshake: a request is accepted on a rising edge where ready=1 and
// next=1. From that edge ready stays low for exactly N cycles. ready then
// rises on the same edge that loads new_block. Requests made while ready=0
// are dropped and are not queued.
// ---------------------------------------------------------------------------
module encipher_block #(
   parameter int ROUNDS_128 = 10,
   parameter int ROUNDS_256 = 14
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         next,
   input  logic [3:0]   keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready
);

   localparam logic [3:0] R128 = 4'(ROUNDS_128);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic {
      IDLE  = 1'b0,
      ROUND = 1'b1
   } fsm_t;

   fsm_t         fsm_state;
   logic [127:0] state;
   logic [3:0]   last_round;
   logic [127:0] sr_out;
   logic [127:0] mid_out;
   logic [127:0] final_out;

   // Byte i of the state is s[127-8*i -: 8]. The state is column-major,
   // so byte i sits at row i%4 and column i/4.
   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
      end
      return r;
   endfunction

   // Rotate row r left by r positions: out[r][c] = in[r][(c+r)%4].
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) begin
            r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   // The middle and final rounds share SubBytes and ShiftRows. Only the
   // middle rounds go through MixColumns.
   assign sr_out    = shift_rows(sub_bytes(state));
   assign mid_out   = mix_columns(sr_out) ^ round_key;
   assign final_out = sr_out ^ round_key;

`ifdef ENCIPHER_AES256_EN
   localparam logic [3:0] R256 = 4'(ROUNDS_256);
   logic use_256;
   assign last_round = use_256 ? R256 : R128;
`else
   // keylen has no function in the 128-only build.
   logic unused_keylen;
   assign unused_keylen = ^keylen;
   assign last_round    = R128;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fsm_state <= IDLE;
         ready     <= 1'b1;
         round     <= 4'd0;
         new_block <= '0;
         state     <= '0;
`ifdef ENCIPHER_AES256_EN
         use_256   <= 1'b0;
`endif
      end else begin
         case (fsm_state)
            IDLE: begin
               if (next) begin
                  // round is 0 while idle, so round_key holds the whitening key.
                  state     <= block ^ round_key;
                  round     <= 4'd1;
                  ready     <= 1'b0;
                  fsm_state <= ROUND;
`ifdef ENCIPHER_AES256_EN
                  use_256   <= (keylen == 4'h2);
`endif
               end
            end
            ROUND: begin
               if (round == last_round) begin
                  new_block <= final_out;
                  ready     <= 1'b1;
                  round     <= 4'd0;
                  fsm_state <= IDLE;
               end else begin
                  state <= mid_out;
                  round <= round + 4'd1;
               end
            end
            default: begin
               fsm_state <= IDLE;
               ready     <= 1'b1;
               round     <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encipher_block.sv
// ---------------------------------------------------------------------------
// tb_encipher_block
//   Bench for encipher_block. It builds its own S-box from the GF(2^8)
//   inverse and the affine map. It expands keys into a round-key table that
//   drives round_key combinationally from the DUT's round output. Expected
//   ciphertexts come from the published FIPS-197 and SP800-38A vectors.
// ---------------------------------------------------------------------------
module tb_encipher_block;

   logic         clk;
   logic         reset_n;
   logic         next;
   logic [3:0]   keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   logic [7:0]   sb [0:255];
   logic [127:0] rk [0:15];
   logic [127:0] exp_q [$];
   logic [127:0] last_result;
   int           n_tests;
   int           n_fail;

   encipher_block dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .next      (next),
      .keylen    (keylen),
      .round     (round),
      .round_key (round_key),
      .block     (block),
      .new_block (new_block),
      .ready     (ready)
   );

   assign round_key = rk[round];

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- GF helpers for the reference S-box / key schedule ----
   function automatic logic [7:0] gx(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = gx(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // key is left-aligned: an AES-128 key occupies key[255:128].
   task automatic expand_key(input logic [255:0] key, input bit is256);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rcon;
      int          nk, nw;
      nk   = is256 ? 8 : 4;
      nw   = is256 ? 60 : 44;
      rcon = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < nw; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = gx(rcon);
         end else if (nk == 8 && i % 8 == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         if (4 * r + 3 < nw) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else                rk[r] = '0;
      end
   endtask

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Call on a negedge with the DUT idle. Returns on the negedge after the start edge.
   task automatic start_op(input logic [127:0] pt, input logic [3:0] kl, input logic [127:0] exp);
      block  = pt;
      keylen = kl;
      next   = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
   endtask

   // Follows one busy period. next stays high for `hold` cycles, counted from
   // the start cycle. On the cycle after that, block and keylen are scrambled.
   task automatic wait_done(input int n_exp, input int hold);
      int           cnt;
      logic [127:0] exp;
      cnt = 0;
      while (!ready && cnt < 40) begin
         if (cnt == 0) check("new_block_held", new_block, last_result);
         check("round_seq", 128'(round), 128'(cnt + 1));
         if (cnt + 1 >= hold) next = 1'b0;
         if (cnt == hold) begin
            block  = {$urandom, $urandom, $urandom, $urandom};
            keylen = 4'($urandom_range(0, 15));
         end
         @(negedge clk);
         cnt++;
      end
      check("busy_cycles", 128'(cnt), 128'(n_exp));
      check("round_idle", 128'(round), 128'd0);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("ciphertext", new_block, exp);
      last_result = exp;
   endtask

   // ---------------- vectors ----------------
   localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P_C1   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_SP   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P_SP [0:3] = '{
      128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
      128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
   localparam logic [127:0] C_SP [0:3] = '{
      128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
      128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4};
`ifdef ENCIPHER_AES256_EN
   localparam logic [255:0] K_256  =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] C_256  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
`endif

   // ---------------- main sequence ----------------
   initial begin
      int cnt;
      n_tests     = 0;
      n_fail      = 0;
      last_result = '0;
      reset_n     = 1'b0;
      next        = 1'b0;
      keylen      = 4'h0;
      block       = '0;
      build_sbox();
      expand_key({K_C1, 128'h0}, 1'b0);

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_ready", 128'(ready), 128'd1);
      check("reset_round", 128'(round), 128'd0);
      check("reset_new_block", new_block, '0);
      reset_n = 1'b1;
      @(negedge clk);

      // FIPS-197 C.1, then the next input is left low and the core must stay idle
      start_op(P_C1, 4'h0, C_C1);
      wait_done(10, 1);
      @(negedge clk);
      check("idle_stays_ready", 128'(ready), 128'd1);

      // SP800-38A ECB-AES128, four blocks
      expand_key({K_SP, 128'h0}, 1'b0);
      for (int i = 0; i < 4; i++) begin
         start_op(P_SP[i], 4'h0, C_SP[i]);
         wait_done(10, 1);
      end

      // keylen 192 runs as 128
      start_op(P_SP[0], 4'h1, C_SP[0]);
      wait_done(10, 1);

      // next held for 4 cycles, then block/keylen scrambled while busy
      start_op(P_SP[1], 4'h0, C_SP[1]);
      wait_done(10, 4);
      @(negedge clk);
      check("no_queued_start", 128'(ready), 128'd1);

      // next held across completion: a second operation starts immediately
      start_op(P_SP[2], 4'h0, C_SP[2]);
      block = P_SP[3];
      wait_done(10, 99);
      exp_q.push_back(C_SP[3]);
      @(negedge clk);
      check("back_to_back_start", 128'(ready), 128'd0);
      wait_done(10, 1);

      // reset in the middle of an operation, then restart
      start_op(P_C1, 4'h0, '0);
      expand_key({K_C1, 128'h0}, 1'b0);
      next = 1'b0;
      cnt  = 0;
      while (round != 4'd5 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("reached_round5", 128'(round), 128'd5);
      reset_n = 1'b0;
      @(negedge clk);
      check("abort_ready", 128'(ready), 128'd1);
      check("abort_round", 128'(round), 128'd0);
      check("abort_new_block", new_block, '0);
      reset_n = 1'b1;
      void'(exp_q.pop_front());
      last_result = '0;
      @(negedge clk);
      start_op(P_C1, 4'h0, C_C1);
      wait_done(10, 1);

`ifdef ENCIPHER_AES256_EN
      expand_key(K_256, 1'b1);
      start_op(P_SP[0], 4'h2, C_256);
      wait_done(14, 1);
`else
      // keylen is ignored in the 128-only build
      expand_key({K_SP, 128'h0}, 1'b0);
      start_op(P_SP[0], 4'h2, C_SP[0]);
      wait_done(10, 1);
`endif

      check("queue_empty", 128'(exp_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
